// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: rebuilds channel-voice messages (with running status),
// passes real-time bytes through, and flags protocol violations. All outputs registered.
module midi_msg_parser #(
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ev_valid,
  output logic [2:0] ev_type,
  output logic [3:0] ev_chan,
  output logic [6:0] ev_d1,
  output logic [6:0] ev_d2,
  output logic       rt_valid,
  output logic [7:0] rt_code,
  output logic       err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D1 = 2'd1;
  localparam logic [1:0] WAIT_D2 = 2'd2;
  localparam logic [1:0] SKIP    = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  // Set by a status byte, cleared once a message completes under that status.
  logic       fresh_q, fresh_d;

  logic       ev_valid_q, ev_valid_d;
  logic [2:0] ev_type_q, ev_type_d;
  logic [3:0] ev_chan_q, ev_chan_d;
  logic [6:0] ev_d1_q, ev_d1_d;
  logic [6:0] ev_d2_q, ev_d2_d;
  logic       rt_valid_q, rt_valid_d;
  logic [7:0] rt_code_q, rt_code_d;
  logic       err_q, err_d;

  logic       emit;
  logic [6:0] emit_d1;
  logic [6:0] emit_d2;
  logic [2:0] msg_type;
  logic       one_byte;

  assign msg_type = status_q[6:4];
  assign one_byte = (msg_type == 3'd4) || (msg_type == 3'd5);

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    d1_d       = d1_q;
    fresh_d    = fresh_q;
    ev_valid_d = 1'b0;
    ev_type_d  = ev_type_q;
    ev_chan_d  = ev_chan_q;
    ev_d1_d    = ev_d1_q;
    ev_d2_d    = ev_d2_q;
    rt_valid_d = 1'b0;
    rt_code_d  = rt_code_q;
    err_d      = 1'b0;
    emit       = 1'b0;
    emit_d1    = 7'd0;
    emit_d2    = 7'd0;

    if (rx_valid) begin
      if (rx_data[7:3] == 5'b11111) begin
        rt_valid_d = 1'b1;
        rt_code_d  = rx_data;
      end else if (rx_data[7:4] == 4'hF) begin
        status_d = 8'h00;
        state_d  = SKIP;
        fresh_d  = 1'b0;
      end else if (rx_data[7]) begin
        if ((state_q == WAIT_D2) || ((state_q == WAIT_D1) && fresh_q))
          err_d = 1'b1;
        status_d = rx_data;
        state_d  = WAIT_D1;
        fresh_d  = 1'b1;
      end else begin
        case (state_q)
          IDLE: err_d = 1'b1;
          WAIT_D1: begin
            if (one_byte) begin
              emit    = 1'b1;
              emit_d1 = rx_data[6:0];
              fresh_d = 1'b0;
            end else begin
              d1_d    = rx_data[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1_q;
            emit_d2 = rx_data[6:0];
            state_d = WAIT_D1;
            fresh_d = 1'b0;
          end
          default: ;
        endcase
      end
    end

    // Masked channels still advance the parser; only the output event is suppressed.
    if (emit && CHANNEL_MASK[status_q[3:0]]) begin
      ev_valid_d = 1'b1;
      ev_type_d  = ((msg_type == 3'd1) && (emit_d2 == 7'd0)) ? 3'd0 : msg_type;
      ev_chan_d  = status_q[3:0];
      ev_d1_d    = emit_d1;
      ev_d2_d    = emit_d2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      status_q   <= 8'h00;
      d1_q       <= 7'd0;
      fresh_q    <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_type_q  <= 3'd0;
      ev_chan_q  <= 4'd0;
      ev_d1_q    <= 7'd0;
      ev_d2_q    <= 7'd0;
      rt_valid_q <= 1'b0;
      rt_code_q  <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      d1_q       <= d1_d;
      fresh_q    <= fresh_d;
      ev_valid_q <= ev_valid_d;
      ev_type_q  <= ev_type_d;
      ev_chan_q  <= ev_chan_d;
      ev_d1_q    <= ev_d1_d;
      ev_d2_q    <= ev_d2_d;
      rt_valid_q <= rt_valid_d;
      rt_code_q  <= rt_code_d;
      err_q      <= err_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_type  = ev_type_q;
  assign ev_chan  = ev_chan_q;
  assign ev_d1    = ev_d1_q;
  assign ev_d2    = ev_d2_q;
  assign rt_valid = rt_valid_q;
  assign rt_code  = rt_code_q;
  assign err      = err_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: an all-channels instance and a channel-0-only instance
// share one byte stream; directed table, reset corner case, then random bytes vs model.
module tb_midi_msg_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;

  logic [1:0]      evv;
  logic [1:0][2:0] typ;
  logic [1:0][3:0] ch;
  logic [1:0][6:0] od1;
  logic [1:0][6:0] od2;
  logic [1:0]      rtv;
  logic [1:0][7:0] rtc;
  logic [1:0]      erv;

  always #5 clk = ~clk;

  midi_msg_parser dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_valid(evv[0]), .ev_type(typ[0]), .ev_chan(ch[0]), .ev_d1(od1[0]), .ev_d2(od2[0]),
    .rt_valid(rtv[0]), .rt_code(rtc[0]), .err(erv[0])
  );

  midi_msg_parser #(.CHANNEL_MASK(16'h0001)) dut_m (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_valid(evv[1]), .ev_type(typ[1]), .ev_chan(ch[1]), .ev_d1(od1[1]), .ev_d2(od2[1]),
    .rt_valid(rtv[1]), .rt_code(rtc[1]), .err(erv[1])
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: message = status + N data bytes, N from the message type.
  logic [15:0] mask [2] = '{16'hFFFF, 16'h0001};
  int          m_status;
  bit          m_skip;
  bit          m_done_any;
  int          m_data [$];
  bit          e_ev [2];
  bit          e_rt, e_err;
  logic [7:0]  h_code;
  logic [2:0]  h_typ [2];
  logic [3:0]  h_ch  [2];
  logic [6:0]  h_d1  [2];
  logic [6:0]  h_d2  [2];

  task automatic model_reset();
    m_status = 0; m_skip = 0; m_done_any = 0; m_data.delete();
    h_code = 0;
    for (int k = 0; k < 2; k++) begin
      h_typ[k] = 0; h_ch[k] = 0; h_d1[k] = 0; h_d2[k] = 0;
    end
  endtask

  task automatic model_clear_pulses();
    e_ev[0] = 0; e_ev[1] = 0; e_rt = 0; e_err = 0;
  endtask

  task automatic model_byte(input int b);
    int need, t, c, a1, a2;
    model_clear_pulses();
    if (b >= 'hF8) begin
      e_rt = 1; h_code = b[7:0];
    end else if (b >= 'hF0) begin
      m_status = 0; m_skip = 1; m_data.delete();
    end else if (b >= 'h80) begin
      if (m_status != 0 && (m_data.size() > 0 || !m_done_any)) e_err = 1;
      m_status = b; m_skip = 0; m_done_any = 0; m_data.delete();
    end else if (m_skip) begin
      // sysex payload or stray data after system common: ignored
    end else if (m_status == 0) begin
      e_err = 1;
    end else begin
      m_data.push_back(b);
      t = (m_status / 16) % 8;
      c = m_status % 16;
      need = (t == 4 || t == 5) ? 1 : 2;
      if (m_data.size() == need) begin
        a1 = m_data[0];
        a2 = (need == 2) ? m_data[1] : 0;
        if (t == 1 && a2 == 0) t = 0;
        for (int k = 0; k < 2; k++) begin
          if (mask[k][c]) begin
            e_ev[k] = 1;
            h_typ[k] = t[2:0]; h_ch[k] = c[3:0]; h_d1[k] = a1[6:0]; h_d2[k] = a2[6:0];
          end
        end
        m_data.delete();
        m_done_any = 1;
      end
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ev_valid[%0d]", k), evv[k], e_ev[k]);
      chk($sformatf("ev_type[%0d]", k), typ[k], h_typ[k]);
      chk($sformatf("ev_chan[%0d]", k), ch[k], h_ch[k]);
      chk($sformatf("ev_d1[%0d]", k), od1[k], h_d1[k]);
      chk($sformatf("ev_d2[%0d]", k), od2[k], h_d2[k]);
      chk($sformatf("rt_valid[%0d]", k), rtv[k], e_rt);
      chk($sformatf("rt_code[%0d]", k), rtc[k], h_code);
      chk($sformatf("err[%0d]", k), erv[k], e_err);
    end
  endtask

  // One clock of stimulus; outputs are checked 1 ns after the following rising edge.
  task automatic step(input bit v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = b;
    if (v) model_byte(b);
    else model_clear_pulses();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [7:0] b;
    bit         ev;
    bit         evm;
    logic [2:0] t;
    logic [3:0] c;
    logic [6:0] d1;
    logic [6:0] d2;
    bit         rt;
    bit         er;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [7:0] b, input bit ev, input bit evm, input logic [2:0] t,
                     input logic [3:0] c, input logic [6:0] d1, input logic [6:0] d2,
                     input bit rt, input bit er);
    vec_t v;
    v.b = b; v.ev = ev; v.evm = evm; v.t = t; v.c = c; v.d1 = d1; v.d2 = d2; v.rt = rt; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic add_q(input logic [7:0] b);
    add(b, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    model_clear_pulses();
    // note-on
    add_q(8'h90); add_q(8'h3C); add(8'h64, 1, 1, 1, 0, 7'h3C, 7'h64, 0, 0);
    // running status, velocity 0
    add_q(8'h93); add_q(8'h40); add(8'h7F, 1, 0, 1, 3, 7'h40, 7'h7F, 0, 0);
    add_q(8'h40); add(8'h00, 1, 0, 0, 3, 7'h40, 7'h00, 0, 0);
    // real-time interleave
    add_q(8'h90); add_q(8'h3C); add(8'hF8, 0, 0, 0, 0, 0, 0, 1, 0);
    add(8'h64, 1, 1, 1, 0, 7'h3C, 7'h64, 0, 0);
    // program change, running status
    add_q(8'hC5); add(8'h07, 1, 0, 4, 5, 7'h07, 0, 0, 0); add(8'h07, 1, 0, 4, 5, 7'h07, 0, 0, 0);
    // incomplete note-on interrupted by control change
    add_q(8'h90); add_q(8'h3C); add(8'hB0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_q(8'h01); add(8'h02, 1, 1, 3, 0, 7'h01, 7'h02, 0, 0);
    // status with no data at all, then a status after a completed message
    add_q(8'h90); add(8'hC0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(8'h07, 1, 1, 4, 0, 7'h07, 0, 0, 0); add_q(8'h90);
    // sysex then stray data: silent
    add_q(8'hF0); add_q(8'h7E); add_q(8'h01); add_q(8'h02); add_q(8'hF7); add_q(8'h3C);
    // channel mask
    add_q(8'h91); add_q(8'h3C); add(8'h64, 1, 0, 1, 1, 7'h3C, 7'h64, 0, 0);
    add_q(8'h90); add_q(8'h3C); add(8'h64, 1, 1, 1, 0, 7'h3C, 7'h64, 0, 0);
    // pitch bend and channel pressure
    add_q(8'hE2); add_q(8'h00); add(8'h40, 1, 0, 6, 2, 7'h00, 7'h40, 0, 0);
    add_q(8'hD1); add(8'h55, 1, 0, 5, 1, 7'h55, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(1, tbl[i].b);
      chk($sformatf("tbl%0d ev", i), evv[0], tbl[i].ev);
      chk($sformatf("tbl%0d ev_masked", i), evv[1], tbl[i].evm);
      chk($sformatf("tbl%0d rt", i), rtv[0], tbl[i].rt);
      chk($sformatf("tbl%0d err", i), erv[0], tbl[i].er);
      if (tbl[i].rt) chk($sformatf("tbl%0d rt_code", i), rtc[0], tbl[i].b);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d type", i), typ[0], tbl[i].t);
        chk($sformatf("tbl%0d chan", i), ch[0], tbl[i].c);
        chk($sformatf("tbl%0d d1", i), od1[0], tbl[i].d1);
        chk($sformatf("tbl%0d d2", i), od2[0], tbl[i].d2);
      end
    end
    // idle gap: outputs must hold, pulses drop
    step(0, 8'h90);
    step(0, 8'h05);

    // async reset in the middle of a note-on
    step(1, 8'h90);
    step(1, 8'h3C);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    model_clear_pulses();
    compare_model();
    @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h64);
    chk("post-reset stray err", erv[0], 1'b1);
    chk("post-reset no event", evv[0], 1'b0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 50) b = 8'($urandom_range(8'h00, 8'h7F));
      else if (r < 78) b = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
      else b = 8'($urandom_range(8'hF0, 8'hF7));
      step($urandom_range(0, 9) < 8, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Byte-level MIDI message parser sitting directly downstream of `MIDI_RX`. It consumes one received UART byte per strobe and reassembles complete channel-voice messages, honouring running status. It emits one single-cycle event pulse per message for the synth voice logic, and passes system real-time bytes through on a separate strobe.

## Interface

Parameters:
- `CHANNEL_MASK`, default 16'hFFFF: bit n = 1 accepts MIDI channel n. Messages on masked channels are parsed but not emitted.

Ports:
- `clk`  in  1  100 MHz system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from `MIDI_RX`.
- `rx_valid`  in  1  single-cycle strobe; `rx_data` is valid while high.
- `ev_valid`  out  1  single-cycle pulse: a complete channel message is available.
- `ev_type`  out  3  status[6:4]: 0 note-off, 1 note-on, 2 poly aftertouch, 3 control change, 4 program change, 5 channel pressure, 6 pitch bend.
- `ev_chan`  out  4  status[3:0].
- `ev_d1`  out  7  first data byte.
- `ev_d2`  out  7  second data byte; 0 for one-data-byte messages.
- `rt_valid`  out  1  single-cycle pulse on a real-time byte (F8–FF).
- `rt_code`  out  8  the real-time byte.
- `err`  out  1  single-cycle pulse on a protocol violation.

## Operation

Registers:
- `status[7:0]` holds the running status. 0 means none.
- `d1[6:0]` holds the first data byte.
- `state` is one of IDLE, WAIT_D1, WAIT_D2, SKIP.

Byte classification applies only when `rx_valid` is high:
- **Real-time (F8–FF):**
  - `rt_valid` = 1 and `rt_code` = byte.
  - State, status and d1 are untouched, including mid-message.
- **Channel status (80–EF):**
  - `status` ← byte, then go to WAIT_D1.
  - If the previous message was incomplete (state WAIT_D2, or state WAIT_D1 entered directly by a status byte), it is discarded and `err` pulses.
- **SysEx / system common (F0–F7):**
  - `status` ← 0, then go to SKIP.
  - No error is raised for an abandoned partial channel message in this case.
- **Data byte (00–7F), by state:**
  - IDLE: discard and pulse `err`.
  - SKIP: discard silently. The state stays SKIP until the next status byte.
  - WAIT_D1, one-byte message type (4, 5): emit the event with `ev_d2` = 0, then stay in WAIT_D1 (running status).
  - WAIT_D1, two-byte message type: `d1` ← byte, then go to WAIT_D2.
  - WAIT_D2: emit the event with d1 and the byte, then return to WAIT_D1 (running status).

Event rules:
- **Note-on with velocity 0:** emitted as `ev_type` = 0 with `ev_d2` = 0.
- **Channel mask:** if `CHANNEL_MASK[status[3:0]]` is 0, `ev_valid` stays low. The state machine advances identically.
- **Status F7:** goes to SKIP. It does not return to IDLE.
- **Byte stream:** bytes with `rx_valid` low are ignored. Back-to-back strobes on consecutive cycles must be accepted.

## Timing

- All outputs are registered.
- `ev_valid`, `rt_valid` and `err` assert exactly 1 cycle after the `rx_valid` cycle of the triggering byte, and stay high for 1 cycle.
- `ev_type`, `ev_chan`, `ev_d1` and `ev_d2` hold their values until the next event.
- There is no backpressure. The consumer must sample the event on the `ev_valid` cycle.
- Reset (asynchronous assert, synchronous deassert by the system):
  - All outputs go to 0.
  - `state` = IDLE, `status` = 0, `d1` = 0.
- Reset mid-message drops the partial message with no event and no err.
- A real-time byte and an event can never coincide, because there is only one input byte per cycle.

## Test plan

- **Note-on:** 90 3C 64 → one `ev_valid` with type 1, chan 0, d1 3C, d2 64, asserted 1 cycle after the 64 strobe.
- **Running status and velocity 0:** 93 40 7F, then 40 00 → two events: (type 1, chan 3, d1 40, d2 7F), then (type 0, chan 3, d1 40, d2 0).
- **Real-time interleave:** 90 3C F8 64 → `rt_valid` with `rt_code` F8 after the F8 strobe, then the note-on event 3C/64 intact. No err.
- **One-byte messages and error paths:**
  - C5 07 07 → two program-change events with chan 5, d1 7, d2 0.
  - Stray 22 after reset → `err` pulse, no event.
  - 90 3C B0 → `err` pulse, then B0 waits for its data bytes.
- **SysEx and channel mask:**
  - F0 7E 01 02 F7 3C → no events and no err.
  - With `CHANNEL_MASK` = 16'h0001, 91 3C 64 → no event, then 90 3C 64 → event.
- **Async reset mid-message:** assert `rst_n` low after 90 3C, release, send 64 → all outputs 0 during reset, then `err` pulse from IDLE and no event.
